// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the multiply/divide unit state type.
package riscv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} mdu_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit: one bit per cycle over a shared 64-bit
// accumulator, sign fixup in a separate cycle, result held until consumed.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              neg_q, neg_d;
  logic              special_q, special_d;

  logic              sgn_a, sgn_b, is_div, is_rem;
  logic [XLEN-1:0]   mag_a, mag_b, quo, rem;
  logic [XLEN:0]     mul_sum, div_top, div_diff;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    neg_d     = neg_q;
    special_d = special_q;

    is_div = funct3[2];
    is_rem = funct3[1];
    sgn_a  = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
             (funct3 == F3_DIV) || (funct3 == F3_REM);
    sgn_b  = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
             (funct3 == F3_DIV) || (funct3 == F3_REM);
    mag_a  = (sgn_a && op_a[XLEN-1]) ? -op_a : op_a;
    mag_b  = (sgn_b && op_b[XLEN-1]) ? -op_b : op_b;

    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    div_top  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_top - {1'b0, opnd_q};

    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          f3_d      = funct3;
          rd_d      = rd;
          cnt_d     = '0;
          special_d = 1'b0;
          state_d   = CALC;
          if (is_div) begin
            // Dividend in the low half shifts up into the remainder half.
            acc_d  = {{XLEN{1'b0}}, mag_a};
            opnd_d = mag_b;
            neg_d  = is_rem ? (sgn_a & op_a[XLEN-1])
                            : (sgn_a & (op_a[XLEN-1] ^ op_b[XLEN-1]));
            if (op_b == '0) begin
              special_d = 1'b1;
              result_d  = is_rem ? op_a : '1;
            end else if (sgn_a && op_a == INT_MIN && op_b == '1) begin
              special_d = 1'b1;
              result_d  = is_rem ? '0 : INT_MIN;
            end
            // Special results bypass CALC and surface one edge later.
            if (special_d) state_d = FIXUP;
          end else begin
            acc_d  = {{XLEN{1'b0}}, mag_b};
            opnd_d = mag_a;
            neg_d  = (sgn_a & op_a[XLEN-1]) ^ (sgn_b & op_b[XLEN-1]);
          end
        end
      end
      CALC: begin
        if (f3_q[2]) begin
          if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                 acc_d = {div_top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = FIXUP;
      end
      FIXUP: begin
        if (!special_q) begin
          unique case (f3_q)
            F3_MUL:                     result_d = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:            result_d = quo;
            default:                    result_d = rem;
          endcase
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  // Control plus the externally visible result/tag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q     <= cnt_d;
    f3_q      <= f3_d;
    acc_q     <= acc_d;
    opnd_q    <= opnd_d;
    neg_q     <= neg_d;
    special_q <= special_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign out_rd    = rd_q;

endmodule
